// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants and types for the adder-sharing arbiter slice.
// Used by the interface, the round-robin arbiter and the top level.
package adder_share_pkg;

    localparam int A_W_DEF   = 50;
    localparam int B_W_DEF   = 35;
    localparam int SUM_W     = A_W_DEF + 1;
    localparam int N_REQ_DEF = 2;
    localparam int ID_W_DEF  = 1;
    localparam int CNT_W     = 16;

    typedef logic [SUM_W-1:0]    sum_t;
    typedef logic [ID_W_DEF-1:0] id_t;

    // Requester ID width for a given requester count (never below one bit).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between the partial-product reduction stages
// (master side) and the shared-adder arbiter (slave side).
interface adder_share_arbiter_if
    import adder_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ID_W  = ID_W_DEF
);

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [A_W:0]         rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );

endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr and wrapping,
// granting the first set bit. No grant when en is low.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    logic            found;
    logic [ID_W-1:0] idx_v;

    // Priority scan from ptr, wrapping modulo N_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_v     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = ID_W'((int'(ptr) + k) % N_REQ);
            if (en && !found && req[idx_v]) begin
                found        = 1'b1;
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
            end
        end
    end

endmodule

// File: rtl/unsignedRippleCarryAdder50bit.sv
// 50-bit unsigned ripple-carry adder; sum[50] is the carry-out.
module unsignedRippleCarryAdder50bit (
    input  logic [49:0] a,
    input  logic [49:0] b,
    output logic [50:0] sum
);

    logic [50:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 50; gi++) begin : g_fa
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign sum[50] = carry[50];

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one unsigned adder (A + zero-extended B) among N_REQ
// requesters. A round-robin arbiter picks one request per cycle whenever the
// single response stage is free; the sum is registered with the requester ID.
// Optional: define ADDER_SHARE_PERF_EN to add per-requester grant counters
// and a stall counter (16-bit, saturating).
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adder_share_arbiter_if.slave   bus
`ifdef ADDER_SHARE_PERF_EN
    ,
    output logic [N_REQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]       stall_cnt
`endif
);

    logic             rsp_valid_reg;
    logic [A_W:0]     rsp_sum_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  ptr_next;

    logic             free;
    logic             arb_en;
    logic             fire;
    logic [N_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]  grant_idx;

    logic [A_W-1:0]   a_arr [N_REQ];
    logic [B_W-1:0]   b_arr [N_REQ];
    logic [A_W-1:0]   a_sel;
    logic [A_W-1:0]   b_ext;
    logic [A_W:0]     sum_w;

    // The response stage can take a new sum when empty or being drained.
    // Gating with rst_n keeps req_ready low while reset is held.
    assign free   = !rsp_valid_reg || bus.rsp_ready;
    assign arb_en = free && rst_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_reg),
        .en        (arb_en),
        .grant     (grant_onehot),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = grant_onehot;
    assign fire          = |(bus.req_valid & grant_onehot);

    // Unpack the per-requester operand lanes.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign a_arr[gi] = bus.req_a[gi*A_W +: A_W];
            assign b_arr[gi] = bus.req_b[gi*B_W +: B_W];
        end
    endgenerate

    assign a_sel = a_arr[grant_idx];
    assign b_ext = {{(A_W-B_W){1'b0}}, b_arr[grant_idx]};

    // Use the existing 50-bit adder at the native width; fall back to a
    // plain add for other operand widths.
    generate
        if (A_W == A_W_DEF) begin : g_rca
            sum_t rca_sum;
            unsignedRippleCarryAdder50bit u_add (
                .a   (a_sel),
                .b   (b_ext),
                .sum (rca_sum)
            );
            assign sum_w = rca_sum;
        end else begin : g_plain
            assign sum_w = {1'b0, a_sel} + {1'b0, b_ext};
        end
    endgenerate

    // Pointer moves to the requester after the one just granted.
    assign ptr_next = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

    // Response stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_sum_reg   <= '0;
            rsp_id_reg    <= '0;
            ptr_reg       <= '0;
        end else if (fire) begin
            rsp_valid_reg <= 1'b1;
            rsp_sum_reg   <= sum_w;
            rsp_id_reg    <= grant_idx;
            ptr_reg       <= ptr_next;
        end else if (rsp_valid_reg && bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_sum   = rsp_sum_reg;
    assign bus.rsp_id    = rsp_id_reg;

`ifdef ADDER_SHARE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gcnt
            logic [CNT_W-1:0] cnt_reg;

            // Saturating count of accepted requests for this requester.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (bus.req_valid[gi] && grant_onehot[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    // Saturating count of cycles where backpressure blocks waiting requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (rsp_valid_reg && !bus.rsp_ready && (|bus.req_valid) &&
                     (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed cases with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_adder_share_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 50;
    localparam int BW  = 35;
    localparam int IW  = 1;

    logic clk;
    logic rst_n;

    logic [AW-1:0] op_a [NR];
    logic [BW-1:0] op_b [NR];

    int errors;
    int checks;

    adder_share_arbiter_if #(.N_REQ(NR), .A_W(AW), .B_W(BW), .ID_W(IW)) bus ();

`ifdef ADDER_SHARE_PERF_EN
    logic [NR*16-1:0] grant_cnt;
    logic [15:0]      stall_cnt;
`endif

    adder_share_arbiter #(.N_REQ(NR), .A_W(AW), .B_W(BW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef ADDER_SHARE_PERF_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    assign bus.req_a = {op_a[1], op_a[0]};
    assign bus.req_b = {op_b[1], op_b[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model and per-cycle compare.
    logic          m_valid;
    logic [AW:0]   m_sum;
    int            m_id;
    int            m_ptr;
    logic [NR-1:0] prev_pending;
    int            m_gcnt [NR];
    int            m_stall;

    initial begin
        logic [NR-1:0] exp_ready;
        int            g;
        int            idx;
        m_valid      = 1'b0;
        m_sum        = '0;
        m_id         = 0;
        m_ptr        = 0;
        prev_pending = '0;
        m_stall      = 0;
        for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                check("rst_req_ready", 64'(bus.req_ready), 64'd0);
                m_valid      = 1'b0;
                m_sum        = '0;
                m_id         = 0;
                m_ptr        = 0;
                prev_pending = '0;
                m_stall      = 0;
                for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
            end else begin
                for (int i = 0; i < NR; i++) begin
                    if (prev_pending[i])
                        assert (bus.req_valid[i])
                        else $error("requester %0d dropped valid before acceptance", i);
                end
                check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
                check("rsp_sum", 64'(bus.rsp_sum), 64'(m_sum));
                check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
`ifdef ADDER_SHARE_PERF_EN
                check("grant_cnt0", 64'(grant_cnt[15:0]), 64'(m_gcnt[0]));
                check("grant_cnt1", 64'(grant_cnt[31:16]), 64'(m_gcnt[1]));
                check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
                exp_ready = '0;
                g = -1;
                if (!m_valid || bus.rsp_ready) begin
                    for (int k = 0; k < NR; k++) begin
                        idx = (m_ptr + k) % NR;
                        if (g < 0 && bus.req_valid[idx]) g = idx;
                    end
                end
                if (g >= 0) exp_ready[g] = 1'b1;
                check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
                prev_pending = bus.req_valid & ~bus.req_ready;

                if (m_valid && !bus.rsp_ready && (|bus.req_valid) && m_stall < 65535)
                    m_stall++;
                if (g >= 0) begin
                    m_sum   = (AW+1)'(op_a[g]) + (AW+1)'(op_b[g]);
                    m_id    = g;
                    m_valid = 1'b1;
                    m_ptr   = (g + 1) % NR;
                    if (m_gcnt[g] < 65535) m_gcnt[g]++;
                end else if (m_valid && bus.rsp_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    function automatic logic [AW-1:0] rand_a();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) r = '1;
        return r[AW-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_b();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) r = '1;
        return r[BW-1:0];
    endfunction

    // Directed cases, then randomized traffic.
    initial begin
        logic [AW:0]   held_sum;
        logic [NR-1:0] acc;
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // Reset state, with requests asserted to show req_ready stays low.
        @(negedge clk); #1;
        check("reset_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_sum", 64'(bus.rsp_sum), 64'd0);
        check("reset_id", 64'(bus.rsp_id), 64'd0);
        check("reset_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #2;
        rst_n         = 1'b1;
        bus.req_valid = 2'b00;

        // Single request on requester 0.
        @(posedge clk); #2;
        bus.req_valid = 2'b01;
        op_a[0]       = 50'h3_FFFF_FFFF_FFFF;
        op_b[0]       = 35'h1;
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("single_ready", 64'(bus.req_ready), 64'h1);
        @(posedge clk); #2;
        bus.req_valid = 2'b00;
        @(negedge clk); #1;
        check("single_valid", 64'(bus.rsp_valid), 64'd1);
        check("single_id", 64'(bus.rsp_id), 64'd0);
        check("single_sum", 64'(bus.rsp_sum), 64'h4_0000_0000_0000);

        // Carry-out on requester 1.
        @(posedge clk); #2;
        bus.req_valid = 2'b10;
        op_a[1]       = '1;
        op_b[1]       = '1;
        @(negedge clk); #1;
        check("carry_ready", 64'(bus.req_ready), 64'h2);
        @(posedge clk); #2;
        bus.req_valid = 2'b00;
        @(negedge clk); #1;
        check("carry_sum", 64'(bus.rsp_sum), 64'h4_0007_FFFF_FFFE);
        check("carry_msb", 64'(bus.rsp_sum[AW]), 64'd1);
        check("carry_id", 64'(bus.rsp_id), 64'd1);

        // Round-robin with both valid; backpressure starts after the sixth.
        @(posedge clk); #2;
        bus.req_valid = 2'b11;
        op_a[0] = 50'h123;
        op_b[0] = 35'h10;
        op_a[1] = 50'h2_0000_0000_0000;
        op_b[1] = 35'h7_0000_0000;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            if (k == 5) bus.rsp_ready = 1'b0;
            @(negedge clk); #1;
            check("rr_valid", 64'(bus.rsp_valid), 64'd1);
            check("rr_id", 64'(bus.rsp_id), 64'(k % 2));
        end
        held_sum = bus.rsp_sum;
        check("bp_ready0", 64'(bus.req_ready), 64'd0);
        check("bp_sum_lit", 64'(held_sum), 64'h2_0007_0000_0000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            @(negedge clk); #1;
            check("bp_ready", 64'(bus.req_ready), 64'd0);
            check("bp_id", 64'(bus.rsp_id), 64'd1);
            check("bp_sum", 64'(bus.rsp_sum), 64'(held_sum));
        end
        @(posedge clk); #2;
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_release_ready", 64'(bus.req_ready), 64'h1);

        // Asynchronous reset while a response is pending.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("async_rst_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_ready", 64'(bus.req_ready), 64'h1);

        // Randomized traffic; requesters hold until accepted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk); #2;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        bus.req_valid[i] = 1'b1;
                        op_a[i]          = rand_a();
                        op_b[i]          = rand_b();
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk); #1;
        end

        @(posedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
